// File: rtl/if_id_fifo.sv
// Fetch-to-decode instruction buffer holding (pc, inst) pairs in an explicit-count circular store.
// Latency: an entry pushed at edge N is presented on id_* after that edge; there is no empty bypass.
// Backpressure: if_ready drops at full and depends on registered count only; a flush drops everything.
module if_id_fifo #(
    parameter int          DEPTH    = 2,
    parameter int          PTR_W    = 1,
    parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_inst,
    output logic             if_ready,
    output logic             id_valid,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_inst,
    input  logic             id_ready,
    input  logic             flush,
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     cnt_q;
    logic               push;
    logic               pop;

    // Full/empty come from the count register so if_ready never sees id_ready.
    assign if_ready = (cnt_q != FULL_CNT);
    assign id_valid = (cnt_q != '0);
    assign count    = cnt_q;

    assign push = if_valid & if_ready & ~flush;
    assign pop  = id_valid & id_ready & ~flush;

    assign head    = mem[rd_ptr];
    assign id_pc   = id_valid ? head.pc   : 32'h0;
    assign id_inst = id_valid ? head.inst : NOP_INST;

    // Storage has no reset; stale words are masked by id_valid.
    always_ff @(posedge cpu_clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: if_pc, inst: if_inst};
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (PTR_W + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_fifo.sv
// Directed bench for if_id_fifo with hand-computed expectations at each step.
module tb_if_id_fifo;

    localparam logic [31:0] NOP = 32'h0340_0000;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;
    logic        flush;
    logic [1:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    if_id_fifo #(.DEPTH(2), .PTR_W(1), .NOP_INST(NOP)) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_ready (id_ready),
        .flush    (flush),
        .count    (count)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
    endtask

    initial begin
        cpu_rst  = 1'b1;
        if_valid = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        id_ready = 1'b0;
        flush    = 1'b0;

        // Reset then idle
        #2;
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_inst",  id_inst, NOP);
        chk("rst_id_pc",    id_pc, 32'h0);
        chk("rst_if_ready", {31'b0, if_ready}, 32'd1);
        chk("rst_count",    {30'b0, count}, 32'd0);
        #10 cpu_rst = 1'b0;
        tick();

        // id_ready on an empty buffer must not underflow
        id_ready = 1'b1;
        tick();
        chk("empty_pop_count", {30'b0, count}, 32'd0);
        chk("empty_pop_valid", {31'b0, id_valid}, 32'd0);

        // Single pass-through
        offer(1'b1, 32'h1C00_0000, 32'h0280_0C0C);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        chk("pt_valid", {31'b0, id_valid}, 32'd1);
        chk("pt_pc",    id_pc, 32'h1C00_0000);
        chk("pt_inst",  id_inst, 32'h0280_0C0C);
        chk("pt_count", {30'b0, count}, 32'd1);
        tick();
        chk("pt_drain_count", {30'b0, count}, 32'd0);
        chk("pt_drain_inst",  id_inst, NOP);
        chk("pt_drain_pc",    id_pc, 32'h0);

        // Back-pressure fill
        id_ready = 1'b0;
        offer(1'b1, 32'h1C00_0000, 32'h1111_0000);
        tick();
        offer(1'b1, 32'h1C00_0004, 32'h1111_0004);
        tick();
        offer(1'b1, 32'h1C00_0008, 32'h1111_0008);
        chk("bp_full_count", {30'b0, count}, 32'd2);
        chk("bp_full_ready", {31'b0, if_ready}, 32'd0);
        tick();
        chk("bp_hold_count", {30'b0, count}, 32'd2);
        chk("bp_hold_pc",    id_pc, 32'h1C00_0000);
        id_ready = 1'b1;
        tick();
        chk("bp_pop0_count", {30'b0, count}, 32'd1);
        chk("bp_pop1_pc",    id_pc, 32'h1C00_0004);
        chk("bp_pop1_inst",  id_inst, 32'h1111_0004);
        chk("bp_ready_back", {31'b0, if_ready}, 32'd1);
        tick();
        chk("bp_third_pc",    id_pc, 32'h1C00_0008);
        chk("bp_third_inst",  id_inst, 32'h1111_0008);
        chk("bp_third_count", {30'b0, count}, 32'd1);
        offer(1'b0, 32'h0, 32'h0);
        tick();
        chk("bp_empty_count", {30'b0, count}, 32'd0);

        // Simultaneous push/pop at count=1, wrapping pointers
        id_ready = 1'b0;
        offer(1'b1, 32'h1C00_0200, 32'h2222_0200);
        tick();
        id_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer(1'b1, 32'h1C00_0204 + 32'(4 * i), 32'h2222_0204 + 32'(4 * i));
            chk("pp_head_pc", id_pc, 32'h1C00_0200 + 32'(4 * i));
            chk("pp_count",   {30'b0, count}, 32'd1);
            tick();
        end
        chk("pp_last_pc",    id_pc, 32'h1C00_0214);
        chk("pp_last_inst",  id_inst, 32'h2222_0214);
        chk("pp_last_count", {30'b0, count}, 32'd1);
        offer(1'b0, 32'h0, 32'h0);
        tick();
        chk("pp_drain_count", {30'b0, count}, 32'd0);

        // Flush with concurrent push and pop request
        id_ready = 1'b0;
        offer(1'b1, 32'h1C00_0300, 32'h3333_0300);
        tick();
        offer(1'b1, 32'h1C00_0304, 32'h3333_0304);
        tick();
        chk("fl_pre_count", {30'b0, count}, 32'd2);
        flush = 1'b1;
        id_ready = 1'b1;
        offer(1'b1, 32'h1C00_0100, 32'h3333_0100);
        tick();
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        chk("fl_count", {30'b0, count}, 32'd0);
        chk("fl_valid", {31'b0, id_valid}, 32'd0);
        chk("fl_pc",    id_pc, 32'h0);
        tick();
        chk("fl_stay_valid", {31'b0, id_valid}, 32'd0);
        id_ready = 1'b0;
        offer(1'b1, 32'h1C00_0400, 32'h4444_0400);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        chk("fl_next_pc",    id_pc, 32'h1C00_0400);
        chk("fl_next_count", {30'b0, count}, 32'd1);
        id_ready = 1'b1;
        tick();
        chk("fl_next_drain", {30'b0, count}, 32'd0);

        // Async reset between edges
        id_ready = 1'b0;
        offer(1'b1, 32'h1C00_0500, 32'h5555_0500);
        tick();
        offer(1'b1, 32'h1C00_0504, 32'h5555_0504);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        chk("ar_pre_count", {30'b0, count}, 32'd2);
        #2 cpu_rst = 1'b1;
        #1;
        chk("ar_valid",    {31'b0, id_valid}, 32'd0);
        chk("ar_count",    {30'b0, count}, 32'd0);
        chk("ar_if_ready", {31'b0, if_ready}, 32'd1);
        chk("ar_inst",     id_inst, NOP);
        #1 cpu_rst = 1'b0;
        offer(1'b1, 32'h1C00_0600, 32'h6666_0600);
        tick();
        offer(1'b1, 32'h1C00_0604, 32'h6666_0604);
        chk("ar_push_pc",    id_pc, 32'h1C00_0600);
        chk("ar_push_count", {30'b0, count}, 32'd1);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        chk("ar_full_count", {30'b0, count}, 32'd2);
        chk("ar_full_ready", {31'b0, if_ready}, 32'd0);
        id_ready = 1'b1;
        tick();
        chk("ar_pop_pc",    id_pc, 32'h1C00_0604);
        chk("ar_pop_inst",  id_inst, 32'h6666_0604);
        tick();
        chk("ar_end_count", {30'b0, count}, 32'd0);
        chk("ar_end_inst",  id_inst, NOP);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
